multicycle_seq: RTL and testbench

MULTICYCLE_SEQ -- requirements
Module: multicycle_seq

---
 rtl/multicycle_seq_if.sv | 17 +
 rtl/multicycle_seq.sv | 77 +++++++
 tb/tb_multicycle_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_seq_if.sv
// multicycle_seq_if: memory handshakes, decoder controls and status of the multicycle sequencer
interface multicycle_seq_if;
  logic imem_req, imem_ack, ir_we;
  logic dmem_req, dmem_ack, dmem_we;
  logic MemToReg, MemWrite, RegWrite, Branch, Jump, bit_exit, valid;
  logic rf_we, pc_we, retire, halted;
  logic [2:0] state;
  logic [31:0] cycle_cnt, instret_cnt;
  modport master (
    input imem_ack, dmem_ack, MemToReg, MemWrite, RegWrite, Branch, Jump, bit_exit, valid,
    output imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, retire, halted, state, cycle_cnt, instret_cnt
  );
  modport slave (
    output imem_ack, dmem_ack, MemToReg, MemWrite, RegWrite, Branch, Jump, bit_exit, valid,
    input imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, retire, halted, state, cycle_cnt, instret_cnt
  );
endinterface

// File: rtl/multicycle_seq.sv
// multicycle_seq: fetch/decode/exec/mem/wb control FSM with cycle and retired-instruction counters
module multicycle_seq (
  input logic clk,
  input logic reset,
  multicycle_seq_if.master bus
);
  localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5;
  logic [2:0] state_q, state_d;
  logic mtr_q, mtr_d, mw_q, mw_d, rw_q, rw_d, exit_q, exit_d;
  logic [31:0] cyc_q, cyc_d, ret_q, ret_d;
  logic in_f, in_d, in_e, in_m, in_w, exec_done, retire;
  logic unused_ctl;
  // Branch and Jump need no sequencing of their own: they share the EXEC retire path
  assign unused_ctl = bus.Branch | bus.Jump;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      mtr_q <= 1'b0;
      mw_q <= 1'b0;
      rw_q <= 1'b0;
      exit_q <= 1'b0;
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      state_q <= state_d;
      mtr_q <= mtr_d;
      mw_q <= mw_d;
      rw_q <= rw_d;
      exit_q <= exit_d;
      cyc_q <= cyc_d;
      ret_q <= ret_d;
    end
  end
  always_comb begin
    state_d = HALT;
    case (state_q)
      FETCH: state_d = bus.imem_ack ? DECODE : FETCH;
      DECODE: state_d = bus.bit_exit ? HALT : !bus.valid ? FETCH : EXEC;
      EXEC: state_d = exit_q ? HALT : (mtr_q | mw_q) ? MEM : rw_q ? WB : FETCH;
      MEM: state_d = !bus.dmem_ack ? MEM : mw_q ? FETCH : WB;
      WB: state_d = FETCH;
      default: state_d = HALT;
    endcase
  end
  always_comb begin
    in_f = state_q == FETCH;
    in_d = state_q == DECODE;
    in_e = state_q == EXEC;
    in_m = state_q == MEM;
    in_w = state_q == WB;
    exec_done = in_e & ~exit_q & ~mtr_q & ~mw_q & ~rw_q;
    retire = exec_done | (in_m & bus.dmem_ack & mw_q) | in_w;
    bus.imem_req = in_f;
    bus.ir_we = in_f & bus.imem_ack;
    bus.dmem_req = in_m;
    bus.dmem_we = in_m & mw_q;
    bus.rf_we = in_w;
    bus.pc_we = retire | (in_d & ~bus.bit_exit & ~bus.valid);
    bus.retire = retire;
    bus.halted = state_q == HALT;
    bus.state = state_q;
    bus.cycle_cnt = cyc_q;
    bus.instret_cnt = ret_q;
  end
  always_comb begin
    mtr_d = in_d ? bus.MemToReg : mtr_q;
    mw_d = in_d ? bus.MemWrite : mw_q;
    rw_d = in_d ? bus.RegWrite : rw_q;
    exit_d = in_d ? bus.bit_exit : exit_q;
    cyc_d = state_q != HALT ? cyc_q + 32'd1 : cyc_q;
    ret_d = retire ? ret_q + 32'd1 : ret_q;
  end
  a_store_wb_excl: assert property (@(posedge clk) disable iff (reset)
    !(bus.rf_we && bus.dmem_req && bus.dmem_we));
  a_halt_quiet: assert property (@(posedge clk) disable iff (reset)
    (state_q == HALT) |-> !(bus.imem_req || bus.dmem_req || bus.pc_we || bus.retire));
endmodule

// File: tb/tb_multicycle_seq.sv
// tb_multicycle_seq: instruction-level reference model driving random acks and controls into multicycle_seq
module tb_multicycle_seq;
  localparam bit [6:0] IMR = 7'h40, IRW = 7'h20, DMR = 7'h10, DMW = 7'h08, RFW = 7'h04, PCW = 7'h02, RET = 7'h01;
  typedef enum int {K_ALU, K_BR, K_LD, K_ST, K_ZERO, K_EXIT} kind_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  multicycle_seq_if bus();
  multicycle_seq dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0, n_cycle = 0;
  bit e_on = 1'b0;
  bit [2:0] e_state;
  bit [6:0] e_str;
  bit [31:0] e_cyc, e_ret, m_cyc, m_ret;
  logic [74:0] got, want;
  always @(negedge clk) if (e_on) begin
    got = {bus.state, bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we, bus.rf_we, bus.pc_we,
           bus.retire, bus.halted, bus.cycle_cnt, bus.instret_cnt};
    want = {e_state, e_str, e_state == 3'd5, e_cyc, e_ret};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL cycle_outputs #%0d: got st=%0d str=%b halt=%b cyc=%0d ret=%0d, want st=%0d str=%b halt=%b cyc=%0d ret=%0d",
               n_cycle, got[74:72], got[71:65], got[64], got[63:32], got[31:0],
               want[74:72], want[71:65], want[64], want[63:32], want[31:0]);
    end
  end
  task automatic chk(input string name, input bit [31:0] g, input bit [31:0] w);
    n_cmp++;
    if (g !== w) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, g, w);
    end
  endtask
  function automatic bit rb();
    return 1'($urandom);
  endfunction
  function automatic bit [6:0] rc();
    return 7'($urandom);
  endfunction
  // one clock of stimulus plus the outputs that must be seen during it
  task automatic cyc(input bit [2:0] st, input bit [6:0] s, input bit ia, input bit da, input bit [6:0] c, input bit rs);
    @(posedge clk);
    #1;
    reset = rs;
    bus.imem_ack = ia;
    bus.dmem_ack = da;
    {bus.MemToReg, bus.MemWrite, bus.RegWrite, bus.Branch, bus.Jump, bus.bit_exit, bus.valid} = c;
    e_state = st;
    e_str = s;
    e_cyc = m_cyc;
    e_ret = m_ret;
    e_on = 1'b1;
    n_cycle++;
    if (rs) begin
      m_cyc = 0;
      m_ret = 0;
    end else begin
      if (st != 3'd5) m_cyc++;
      if (s[0]) m_ret++;
    end
  endtask
  task automatic rst_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      reset = 1'b1;
      e_on = 1'b0;
    end
    m_cyc = 0;
    m_ret = 0;
  endtask
  task automatic idle();
    cyc(3'd0, IMR, 1'b0, rb(), rc(), 1'b0);
  endtask
  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(3'd5, 7'd0, rb(), rb(), rc(), 1'b0);
  endtask
  // fd = fetch stall cycles, md = data stall cycles before the ack
  task automatic run_instr(input kind_t k, input int fd, input int md);
    bit [6:0] c;
    bit b;
    bit st_op;
    b = rb();
    case (k)
      K_ALU: c = 7'b0010001;
      K_BR: c = {3'b000, b, ~b, 2'b01};
      K_LD: c = 7'b1010001;
      K_ST: c = 7'b0100001;
      K_ZERO: c = 7'b0000000;
      default: begin
        c = rc();
        c[1] = 1'b1;
      end
    endcase
    for (int i = 0; i < fd; i++) cyc(3'd0, IMR, 1'b0, rb(), rc(), 1'b0);
    cyc(3'd0, IMR | IRW, 1'b1, rb(), rc(), 1'b0);
    if (k == K_EXIT) begin
      cyc(3'd1, 7'd0, rb(), rb(), c, 1'b0);
      return;
    end
    if (k == K_ZERO) begin
      cyc(3'd1, PCW, rb(), rb(), c, 1'b0);
      return;
    end
    cyc(3'd1, 7'd0, rb(), rb(), c, 1'b0);
    cyc(3'd2, k == K_BR ? (PCW | RET) : 7'd0, rb(), rb(), rc(), 1'b0);
    if (k == K_LD || k == K_ST) begin
      st_op = k == K_ST;
      for (int i = 0; i < md; i++) cyc(3'd3, st_op ? (DMR | DMW) : DMR, rb(), 1'b0, rc(), 1'b0);
      cyc(3'd3, st_op ? (DMR | DMW | PCW | RET) : DMR, rb(), 1'b1, rc(), 1'b0);
    end
    if (k == K_ALU || k == K_LD) cyc(3'd4, RFW | PCW | RET, rb(), rb(), rc(), 1'b0);
  endtask
  initial begin
    {bus.imem_ack, bus.dmem_ack} = 2'b00;
    {bus.MemToReg, bus.MemWrite, bus.RegWrite, bus.Branch, bus.Jump, bus.bit_exit, bus.valid} = 7'd0;
    rst_cycles(2);
    run_instr(K_ALU, 0, 0);
    idle();
    chk("alu_cycle_cnt", bus.cycle_cnt, 32'd4);
    chk("alu_instret", bus.instret_cnt, 32'd1);
    rst_cycles(1);
    run_instr(K_LD, 0, 2);
    idle();
    chk("load_cycle_cnt", bus.cycle_cnt, 32'd7);
    chk("load_instret", bus.instret_cnt, 32'd1);
    rst_cycles(1);
    run_instr(K_ST, 0, 0);
    idle();
    chk("store_cycle_cnt", bus.cycle_cnt, 32'd4);
    chk("store_instret", bus.instret_cnt, 32'd1);
    rst_cycles(1);
    run_instr(K_ZERO, 0, 0);
    run_instr(K_BR, 0, 0);
    idle();
    chk("zero_br_cycle_cnt", bus.cycle_cnt, 32'd5);
    chk("zero_br_instret", bus.instret_cnt, 32'd1);
    rst_cycles(1);
    run_instr(K_EXIT, 0, 0);
    halt_cycles(10);
    chk("halt_cycle_frozen", bus.cycle_cnt, 32'd2);
    chk("halt_level", 32'(bus.halted), 32'd1);
    rst_cycles(1);
    idle();
    chk("post_halt_state", 32'(bus.state), 32'd0);
    chk("post_halt_cycle_cnt", bus.cycle_cnt, 32'd0);
    chk("post_halt_halted", 32'(bus.halted), 32'd0);
    rst_cycles(1);
    cyc(3'd0, IMR | IRW, 1'b1, 1'b0, rc(), 1'b0);
    cyc(3'd1, 7'd0, 1'b0, 1'b0, 7'b1010001, 1'b0);
    cyc(3'd2, 7'd0, rb(), rb(), rc(), 1'b0);
    cyc(3'd3, DMR, rb(), 1'b0, rc(), 1'b0);
    cyc(3'd3, DMR, rb(), 1'b0, rc(), 1'b1);
    idle();
    chk("abort_state", 32'(bus.state), 32'd0);
    chk("abort_dmem_req", 32'(bus.dmem_req), 32'd0);
    chk("abort_instret", bus.instret_cnt, 32'd0);
    rst_cycles(1);
    for (int i = 0; i < 120; i++) begin
      run_instr(kind_t'($urandom_range(0, 4)), $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) idle();
    end
    run_instr(K_EXIT, $urandom_range(0, 2), 0);
    halt_cycles(5);
    chk("random_instret", bus.instret_cnt, m_ret);
    @(negedge clk);
    #1;
    e_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
